// File: rtl/harris_line_buffer.sv
// harris_line_buffer: circular NUM_LINES-line buffer that replays stored lines as oldest-first pixel columns
// Ports: pixel/pixel_valid/in_ready raster input; col_data/col_valid/col_ready column output (bits [DATA_W-1:0] = oldest line);
// intrpt requests one new line per pass; frame_done marks the final pass of a frame; ovf flags dropped pixels.
// Optional: define HLB_OVF_DETECT_EN to build the sticky ovf detector, otherwise ovf is tied low.
module harris_line_buffer #(
  parameter int LINE_WIDTH  = 480,
  parameter int NUM_LINES   = 7,
  parameter int FRAME_LINES = 640,
  parameter int DATA_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             pixel,
  input  logic                          pixel_valid,
  output logic                          in_ready,
  output logic [NUM_LINES*DATA_W-1:0]   col_data,
  output logic                          col_valid,
  input  logic                          col_ready,
  output logic                          intrpt,
  output logic                          frame_done,
  output logic                          ovf
);
  localparam int CW  = LINE_WIDTH > 1 ? $clog2(LINE_WIDTH) : 1;
  localparam int SW  = NUM_LINES > 1 ? $clog2(NUM_LINES) : 1;
  localparam int LNW = $clog2(FRAME_LINES + 1);
  typedef enum logic [1:0] {FILL, READ, REFILL} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] mem [NUM_LINES][LINE_WIDTH];
  logic [CW-1:0] wr_col, rd_col, out_col;
  logic [SW-1:0] wr_slot, top;
  logic [LNW-1:0] lines_in;
  logic issued, wr_en, line_end, ld, hs, last_hs, frame_end;
  function automatic logic [SW-1:0] slot_of(input logic [SW-1:0] t, input int k);
    int s;
    s = int'(t) + k;
    return SW'(s >= NUM_LINES ? s - NUM_LINES : s);
  endfunction
  always_comb begin
    in_ready  = state != READ && !reset;
    wr_en     = in_ready && pixel_valid;
    line_end  = wr_en && wr_col == CW'(LINE_WIDTH - 1);
    hs        = col_valid && col_ready;
    last_hs   = hs && out_col == CW'(LINE_WIDTH - 1);
    frame_end = last_hs && lines_in == LNW'(FRAME_LINES);
    ld        = state == READ && !issued && (!col_valid || col_ready);
    nxt = (line_end && (state == REFILL || lines_in == LNW'(NUM_LINES - 1))) ? READ :
          last_hs ? (frame_end ? FILL : REFILL) : state;
  end
  always_ff @(posedge clk) state <= reset ? FILL : nxt;
  always_ff @(posedge clk) if (wr_en) mem[wr_slot][wr_col] <= pixel;
  always_ff @(posedge clk) begin
    if (reset || frame_end) begin
      wr_col   <= '0;
      wr_slot  <= '0;
      top      <= '0;
      lines_in <= '0;
    end else begin
      if (wr_en) wr_col <= line_end ? '0 : wr_col + 1'b1;
      if (line_end) begin
        wr_slot  <= wr_slot == SW'(NUM_LINES - 1) ? '0 : wr_slot + 1'b1;
        lines_in <= lines_in + 1'b1;
      end
      if (last_hs) top <= top == SW'(NUM_LINES - 1) ? '0 : top + 1'b1;
    end
  end
  // The line RAM read register doubles as the col_data output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_col     <= '0;
      out_col    <= '0;
      issued     <= 1'b0;
      col_valid  <= 1'b0;
      col_data   <= '0;
      intrpt     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (ld) begin
        rd_col    <= rd_col == CW'(LINE_WIDTH - 1) ? '0 : rd_col + 1'b1;
        issued    <= rd_col == CW'(LINE_WIDTH - 1);
        col_valid <= 1'b1;
        for (int k = 0; k < NUM_LINES; k++) col_data[k*DATA_W +: DATA_W] <= mem[slot_of(top, k)][rd_col];
      end else if (hs) col_valid <= 1'b0;
      if (hs) out_col <= last_hs ? '0 : out_col + 1'b1;
      if (last_hs) issued <= 1'b0;
      intrpt     <= last_hs && !frame_end;
      frame_done <= frame_end;
    end
  end
`ifdef HLB_OVF_DETECT_EN
  always_ff @(posedge clk) ovf <= reset ? 1'b0 : ovf | (pixel_valid && !in_ready);
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_harris_line_buffer.sv
// tb_harris_line_buffer: directed bench with a window-of-last-lines model and per-handshake column checking
module tb_harris_line_buffer;
  localparam int LW = 4, NL = 3, FL = 5, DW = 8;
  logic clk = 0, reset = 1, pixel_valid = 0, col_ready = 1;
  logic [DW-1:0] pixel = 0;
  logic in_ready, col_valid, intrpt, frame_done, ovf;
  logic [NL*DW-1:0] col_data;
  int tests = 0, fails = 0, n_intrpt = 0, n_fd = 0;
  logic [NL*DW-1:0] exp_q[$];
  int hist[$][LW];
  logic held = 0, prev_intrpt = 0;
  logic [NL*DW-1:0] held_data;
  harris_line_buffer #(.LINE_WIDTH(LW), .NUM_LINES(NL), .FRAME_LINES(FL), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .pixel(pixel), .pixel_valid(pixel_valid), .in_ready(in_ready),
    .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready), .intrpt(intrpt),
    .frame_done(frame_done), .ovf(ovf));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: every completed line joins the history; once NL lines exist the window is the newest NL lines.
  task automatic model_line(input int start);
    int ln[LW];
    logic [NL*DW-1:0] c;
    for (int i = 0; i < LW; i++) ln[i] = start + i;
    hist.push_back(ln);
    if (hist.size() >= NL)
      for (int x = 0; x < LW; x++) begin
        for (int r = 0; r < NL; r++) c[r*DW +: DW] = DW'(hist[hist.size() - NL + r][x]);
        exp_q.push_back(c);
      end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_line(input int start);
    for (int b = 0; b < 50 && !in_ready; b++) tick();
    chk("in_ready_before_line", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < LW; i++) begin
      pixel = DW'(start + i);
      pixel_valid = 1;
      tick();
    end
    model_line(start);
  endtask
  task automatic wait_sig(input string name, input int which);
    int b;
    for (b = 0; b < 60; b++) begin
      if ((which == 0 && intrpt) || (which == 1 && frame_done) || (which == 2 && col_valid)) break;
      tick();
    end
    if (b == 60) chk(name, 64'd0, 64'd1);
  endtask
  always @(negedge clk) begin
    if (reset) held <= 0;
    else begin
      if (held) begin
        chk("bp_valid_held", {63'd0, col_valid}, 64'd1);
        chk("bp_data_stable", 64'(col_data), 64'(held_data));
      end
      held <= col_valid && !col_ready;
      held_data <= col_data;
      if (col_valid && col_ready) begin
        if (exp_q.size() == 0) chk("unexpected_column", 64'(col_data), 64'd0);
        else chk("column", 64'(col_data), 64'(exp_q.pop_front()));
      end
      if (intrpt || frame_done) chk("intrpt_fd_exclusive", {62'd0, intrpt, frame_done}, intrpt ? 64'd2 : 64'd1);
      if (intrpt) chk("intrpt_one_cycle", {63'd0, prev_intrpt}, 64'd0);
    end
    if (intrpt) n_intrpt++;
    if (frame_done) n_fd++;
    prev_intrpt <= intrpt;
  end
  initial begin
    repeat (3) tick();
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    chk("rst_col_valid", {63'd0, col_valid}, 0);
    chk("rst_col_data", 64'(col_data), 0);
    chk("rst_intrpt", {62'd0, intrpt, frame_done}, 0);
    chk("rst_ovf", {63'd0, ovf}, 0);
    reset = 0;
    #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 1);
    for (int l = 0; l < NL; l++) send_line(l * LW);
    pixel_valid = 0;
    chk("in_ready_drop", {63'd0, in_ready}, 0);
    chk("col_valid_lat1", {63'd0, col_valid}, 0);
    tick();
    chk("col_valid_lat2", {63'd0, col_valid}, 1);
    chk("first_col_lit", 64'(col_data), 64'h080400);
    wait_sig("wait_intrpt1", 0);
    chk("in_ready_with_intrpt", {63'd0, in_ready}, 1);
    send_line(12);
    pixel_valid = 0;
    wait_sig("wait_cv2", 2);
    chk("pass2_first_lit", 64'(col_data), 64'h0c0804);
    tick();
    tick();
    col_ready = 0;
    repeat (5) tick();
    col_ready = 1;
    wait_sig("wait_intrpt2", 0);
    send_line(16);
    pixel_valid = 0;
    wait_sig("wait_fd", 1);
    chk("fd_no_intrpt", {63'd0, intrpt}, 0);
    chk("fd_fill_ready", {63'd0, in_ready}, 1);
    chk("intrpt_count_frame", 64'(n_intrpt), 2);
    hist.delete();
    col_ready = 0;
    for (int l = 0; l < NL; l++) send_line(100 + l * LW);
    pixel = 8'hee;
    pixel_valid = 1;
    chk("drop_in_ready", {63'd0, in_ready}, 0);
    tick();
    pixel_valid = 0;
`ifdef HLB_OVF_DETECT_EN
    chk("ovf_set", {63'd0, ovf}, 1);
`else
    chk("ovf_tied", {63'd0, ovf}, 0);
`endif
    col_ready = 1;
    wait_sig("wait_cv3", 2);
    chk("frame2_first_lit", 64'(col_data), 64'h6c6864);
    wait_sig("wait_intrpt3", 0);
    for (int i = 0; i < 2; i++) begin
      pixel = DW'(200 + i);
      pixel_valid = 1;
      tick();
    end
    pixel_valid = 0;
    reset = 1;
    tick();
    chk("mid_rst_in_ready", {63'd0, in_ready}, 0);
    chk("mid_rst_col_valid", {63'd0, col_valid}, 0);
    chk("mid_rst_col_data", 64'(col_data), 0);
    chk("mid_rst_pulses", {62'd0, intrpt, frame_done}, 0);
    chk("mid_rst_ovf", {63'd0, ovf}, 0);
    tick();
    reset = 0;
    chk("queue_empty_before_rst", 64'(exp_q.size()), 0);
    hist.delete();
    for (int l = 0; l < NL; l++) send_line(50 + l * LW);
    pixel_valid = 0;
    wait_sig("wait_cv4", 2);
    chk("restart_first_lit", 64'(col_data), 64'h3a3632);
    wait_sig("wait_intrpt4", 0);
    tick();
    chk("all_columns_seen", 64'(exp_q.size()), 0);
    chk("intrpt_count", 64'(n_intrpt), 4);
    chk("fd_count", 64'(n_fd), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
